// File: rtl/imem_bootld.sv
// Instruction memory with a valid/ready boot-load engine and a 1- or 2-cycle fetch port.
// Define IMEM_PARITY_EN to store even parity per word and add the o_parity_err output.
module imem_bootld #(
    parameter int INSTR_WIDTH  = 32,
    parameter int MEM_DEPTH    = 2048,
    parameter int MEM_DEPTH_W  = $clog2(MEM_DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load_start,
    input  logic [MEM_DEPTH_W-1:0] i_load_base,
    input  logic [MEM_DEPTH_W:0]   i_load_len,
    input  logic                   i_load_valid,
    input  logic [INSTR_WIDTH-1:0] i_load_data,
    output logic                   o_load_ready,
    output logic                   o_load_busy,
    output logic                   o_load_done,
    output logic                   o_load_err,
    input  logic                   i_fetch_req,
    input  logic [MEM_DEPTH_W-1:0] i_fetch_addr,
    output logic                   o_fetch_gnt,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr
`ifdef IMEM_PARITY_EN
    ,
    output logic                   o_parity_err
`endif
);

`ifdef IMEM_PARITY_EN
    localparam int ENTRY_W = INSTR_WIDTH + 1;
`else
    localparam int ENTRY_W = INSTR_WIDTH;
`endif
    localparam logic [MEM_DEPTH_W+1:0] DEPTH_END  = (MEM_DEPTH_W+2)'(MEM_DEPTH);
    localparam logic [MEM_DEPTH_W:0]   DEPTH_ADDR = (MEM_DEPTH_W+1)'(MEM_DEPTH);
    localparam logic [MEM_DEPTH_W:0]   CNT_ONE    = (MEM_DEPTH_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [MEM_DEPTH_W-1:0] r_addr, w_addr_nxt;
    logic [MEM_DEPTH_W:0]   r_cnt, w_cnt_nxt;
    logic                   r_err, w_err_nxt;
    logic                   w_wr_en;
    logic [MEM_DEPTH_W+1:0] w_load_end;
    logic [ENTRY_W-1:0]     w_wr_entry;

    logic [ENTRY_W-1:0]     r_mem [MEM_DEPTH];

    logic                   w_rd_in_range;
    logic [ENTRY_W-1:0]     w_rd_entry;
    logic                   r_v1;
    logic [ENTRY_W-1:0]     r_d1;
    logic                   w_out_valid;
    logic [ENTRY_W-1:0]     w_out_entry;

    // Window end computed two bits wider so base+len can never wrap.
    assign w_load_end = {2'b00, i_load_base} + {1'b0, i_load_len};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load_start) begin
                    if (w_load_end > DEPTH_END) begin
                        w_err_nxt = 1'b1;
                    end else if (i_load_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = i_load_base;
                        w_cnt_nxt   = i_load_len;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_load_valid) begin
                    w_wr_en    = 1'b1;
                    w_addr_nxt = r_addr + MEM_DEPTH_W'(1);
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_load_busy  = (r_state != S_IDLE);
    assign o_load_ready = (r_state == S_LOAD);
    assign o_load_done  = (r_state == S_DONE);
    assign o_load_err   = r_err;
    assign o_fetch_gnt  = i_fetch_req & ~o_load_busy;

`ifdef IMEM_PARITY_EN
    assign w_wr_entry = {^i_load_data, i_load_data};
`else
    assign w_wr_entry = i_load_data;
`endif

    // NOTE: the array has no reset; contents survive rst so an aborted load keeps its words.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_addr] <= w_wr_entry;
        end
    end

    assign w_rd_in_range = ({1'b0, i_fetch_addr} < DEPTH_ADDR);
    assign w_rd_entry    = w_rd_in_range ? r_mem[i_fetch_addr] : '0;

    // Data registers only load on a valid beat, so o_instr holds between fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= o_fetch_gnt;
            if (o_fetch_gnt) begin
                r_d1 <= w_rd_entry;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic               r_v2;
            logic [ENTRY_W-1:0] r_d2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end
            assign w_out_valid = r_v2;
            assign w_out_entry = r_d2;
        end else begin : g_lat1
            assign w_out_valid = r_v1;
            assign w_out_entry = r_d1;
        end
    endgenerate

    assign o_instr_valid = w_out_valid;
    assign o_instr       = w_out_entry[INSTR_WIDTH-1:0];
`ifdef IMEM_PARITY_EN
    // Out-of-range reads return an all-zero entry, whose parity is always clean.
    assign o_parity_err  = w_out_valid & (^w_out_entry);
`endif

endmodule
